rc4_phase_sequencer: RTL and testbench
======================================

# rc4_phase_sequencer

Top-level controller for the RC4 datapath. It runs the three phase FSMs in order (S-array init, key schedule, decrypt/PRGA) with one-cycle start pulses and waits for each phase's done. It owns the single-port `s_memory` and grants its address, data and write-enable to exactly one phase at a time. It sits between the top-level start/key inputs and the phase FSMs, and reports busy, done and error to the top level.

## Interface
- `ADDR_W`, 8, s_memory address width
- `DATA_W`, 8, s_memory data width
- `KEY_W`, 24, secret key width
- `WATCHDOG_CYCLES`, 4096, per-phase timeout; used only with the macro
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: run request, sampled in IDLE/DONE/ERROR
- `key_in` in KEY_W: secret key, latched when a run begins
- `key_out` out KEY_W: latched key to the key-schedule FSM
- `init_start`, `ksa_start`, `prga_start` out 1: one-cycle phase start pulses
- `init_done`, `ksa_done`, `prga_done` in 1: phase completion
- `init_addr`/`ksa_addr`/`prga_addr` in ADDR_W; `*_data` in DATA_W; `*_wren` in 1: per-phase s_memory requests
- `s_memory_addr` out ADDR_W, `s_memory_data` out DATA_W, `s_wren` out 1: granted s_memory port
- `busy` out 1, `done` out 1, `error` out 1, `phase` out 2 (0 none, 1 init, 2 ksa, 3 prga)
- `state` out 16: debug; bits [3:0] state code, [15:4] zero

## Operation
- States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT, DONE, ERROR.
- IDLE, DONE, ERROR: on `start`, latch `key_in` and go to INIT_GO. With no `start`, stay.
- X_GO: assert `x_start` for exactly one cycle, then go to X_WAIT.
- X_WAIT: on `x_done`, go to the next GO state. PRGA_WAIT goes to DONE.
- A done from a phase is honoured only in that phase's WAIT state. Dones from other phases are ignored.
- `start` is ignored while busy.
- Grant: in X_GO and X_WAIT, the s_memory outputs pass phase X's addr/data/wren combinationally.
- Outside a grant: `s_memory_addr`=0, `s_memory_data`=0, `s_wren`=0.
- Non-granted `*_wren` never reaches `s_wren`.
- `busy`=1 in GO/WAIT states. `done`=1 only in DONE. `error`=1 only in ERROR.
- `phase` follows the grant.
- All control outputs are Moore outputs decoded from the registered state.
- Reset (asynchronous, any state, including mid-phase): state IDLE, all `*_start`=0, `busy`=`done`=`error`=0, `phase`=0, `key_out`=0, s_memory outputs 0. Phase FSMs are reset by the same `rst`.

## Timing
- `start` high at edge 0 gives INIT_GO at cycle 1 (`init_start`=1) and INIT_WAIT at cycle 2.
- With each done arriving in the first WAIT cycle, `done` rises at cycle 7. This is the minimum latency.
- Done to next start pulse: 1 cycle. PRGA done to `done`: 1 cycle.
- Mux path is combinational, zero added latency. The phase FSM sees `s_memory_q` with the memory's own read latency.

## Configuration
- `RC4_SEQ_WATCHDOG_EN` defined:
  - A counter clears in each GO state and increments every WAIT cycle.
  - If the count reaches WATCHDOG_CYCLES−1 with no done, go to ERROR and drop the grant.
  - If done and expiry occur in the same cycle, done wins.
  - ERROR leaves only on `start` (to INIT_GO) or on reset.
- Not defined: no counter, ERROR unreachable, `error` tied 0, WATCHDOG_CYCLES unused.

## Structure
- Package `rc4_seq_pkg`:
  - State encoding constants (4-bit codes: IDLE=0 … ERROR=8).
  - Phase codes.
  - Default widths.
- Sub-module `rc4_smem_mux`: 3:1 s_memory request mux, selected by the 2-bit phase code. Code 0 drives zeros.
- Sequencer FSM and watchdog counter stay in the top module.

## Test plan
- Reset mid-INIT_WAIT, then release: `state`=0, `s_wren`=0, `busy`=0. Then `start` pulse, with each done arriving in the first WAIT cycle: `init_start` at cycle 1, `done`=1 at cycle 7, exactly one pulse on each `*_start`.
- During KSA_WAIT drive `ksa_addr`=8'h3C, `ksa_data`=8'hA5, `ksa_wren`=1, and `init_wren`=`prga_wren`=1: outputs are 3C/A5/1. In IDLE, `init_wren`=1 gives `s_wren`=0.
- Pulse `prga_done` during INIT_WAIT: ignored, state remains INIT_WAIT.
- `start` during KSA_WAIT: no restart, no extra `init_start`. `start` in DONE with `key_in`=24'h000249: new run, `key_out`=24'h000249.
- Watchdog build, WATCHDOG_CYCLES=16, `ksa_done` held low: ERROR 16 cycles after entering KSA_WAIT, `error`=1, `s_wren`=0. Done and expiry on the same cycle: advance to PRGA_GO.
- Non-watchdog build, `ksa_done` low for 10000 cycles: stays in KSA_WAIT, `error`=0.

Source files
------------

// File: rtl/rc4_seq_pkg.sv
// Shared types for the RC4 phase sequencer: state codes, phase codes, default widths.
package rc4_seq_pkg;

    localparam int unsigned DefAddrW = 8;
    localparam int unsigned DefDataW = 8;
    localparam int unsigned DefKeyW  = 24;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StInitGo   = 4'd1,
        StInitWait = 4'd2,
        StKsaGo    = 4'd3,
        StKsaWait  = 4'd4,
        StPrgaGo   = 4'd5,
        StPrgaWait = 4'd6,
        StDone     = 4'd7,
        StError    = 4'd8
    } seq_state_e;

    typedef enum logic [1:0] {
        PhNone = 2'd0,
        PhInit = 2'd1,
        PhKsa  = 2'd2,
        PhPrga = 2'd3
    } phase_e;

    // Which phase owns s_memory in a given sequencer state.
    function automatic phase_e phase_of(seq_state_e s);
        case (s)
            StInitGo, StInitWait: phase_of = PhInit;
            StKsaGo, StKsaWait:   phase_of = PhKsa;
            StPrgaGo, StPrgaWait: phase_of = PhPrga;
            default:              phase_of = PhNone;
        endcase
    endfunction

endpackage

// File: rtl/rc4_smem_mux.sv
// 3:1 s_memory request mux; the selected phase's addr/data/wren pass through, PhNone drives 0.
module rc4_smem_mux
    import rc4_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  phase_e              sel,
    input  logic [ADDR_W-1:0]   init_addr,
    input  logic [DATA_W-1:0]   init_data,
    input  logic                init_wren,
    input  logic [ADDR_W-1:0]   ksa_addr,
    input  logic [DATA_W-1:0]   ksa_data,
    input  logic                ksa_wren,
    input  logic [ADDR_W-1:0]   prga_addr,
    input  logic [DATA_W-1:0]   prga_data,
    input  logic                prga_wren,
    output logic [ADDR_W-1:0]   s_memory_addr,
    output logic [DATA_W-1:0]   s_memory_data,
    output logic                s_wren
);

    always_comb begin
        s_memory_addr = '0;
        s_memory_data = '0;
        s_wren        = 1'b0;
        case (sel)
            PhInit: begin
                s_memory_addr = init_addr;
                s_memory_data = init_data;
                s_wren        = init_wren;
            end
            PhKsa: begin
                s_memory_addr = ksa_addr;
                s_memory_data = ksa_data;
                s_wren        = ksa_wren;
            end
            PhPrga: begin
                s_memory_addr = prga_addr;
                s_memory_data = prga_data;
                s_wren        = prga_wren;
            end
            PhNone: ;
        endcase
    end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Runs the RC4 init / key-schedule / PRGA phases in order and grants s_memory to the active one.
// Define RC4_SEQ_WATCHDOG_EN to enable the per-phase timeout that drops into ERROR.
module rc4_phase_sequencer
    import rc4_seq_pkg::*;
#(
    parameter int unsigned ADDR_W          = DefAddrW,
    parameter int unsigned DATA_W          = DefDataW,
    parameter int unsigned KEY_W           = DefKeyW,
    parameter int unsigned WATCHDOG_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  key_in,
    output logic [KEY_W-1:0]  key_out,
    output logic              init_start,
    output logic              ksa_start,
    output logic              prga_start,
    input  logic              init_done,
    input  logic              ksa_done,
    input  logic              prga_done,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_data,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] prga_addr,
    input  logic [DATA_W-1:0] prga_data,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] s_memory_addr,
    output logic [DATA_W-1:0] s_memory_data,
    output logic              s_wren,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        phase,
    output logic [15:0]       state
);

    seq_state_e state_q, state_d;
    phase_e     phase_q;
    logic       run_start;
    logic       wd_expired;

    assign run_start = start && (state_q inside {StIdle, StDone, StError});

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StError: if (run_start) state_d = StInitGo;
            StInitGo:   state_d = StKsaGo == StKsaGo ? StInitWait : StInitWait;
            StInitWait: begin
                if (init_done)       state_d = StKsaGo;
                else if (wd_expired) state_d = StError;
            end
            StKsaGo:    state_d = StKsaWait;
            StKsaWait: begin
                if (ksa_done)        state_d = StPrgaGo;
                else if (wd_expired) state_d = StError;
            end
            StPrgaGo:   state_d = StPrgaWait;
            StPrgaWait: begin
                if (prga_done)       state_d = StDone;
                else if (wd_expired) state_d = StError;
            end
            default:    state_d = StIdle;
        endcase
    end

    // Outputs are registered from state_d so they line up exactly with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            phase_q    <= PhNone;
            key_out    <= '0;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            prga_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef RC4_SEQ_WATCHDOG_EN
            error      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_of(state_d);
            init_start <= (state_d == StInitGo);
            ksa_start  <= (state_d == StKsaGo);
            prga_start <= (state_d == StPrgaGo);
            busy       <= (phase_of(state_d) != PhNone);
            done       <= (state_d == StDone);
`ifdef RC4_SEQ_WATCHDOG_EN
            error      <= (state_d == StError);
`endif
            if (run_start) key_out <= key_in;
        end
    end

`ifdef RC4_SEQ_WATCHDOG_EN
    localparam int unsigned WdW = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;

    logic [WdW-1:0] wd_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q <= '0;
        end else if (state_q inside {StInitGo, StKsaGo, StPrgaGo}) begin
            wd_cnt_q <= '0;
        end else if (state_q inside {StInitWait, StKsaWait, StPrgaWait}) begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
        end
    end

    // A done in the expiry cycle is checked first in the next-state logic, so it wins.
    assign wd_expired = (wd_cnt_q == WdW'(WATCHDOG_CYCLES - 1));
`else
    assign wd_expired = 1'b0;
    assign error      = 1'b0;
`endif

    rc4_smem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_smem_mux (
        .sel           (phase_q),
        .init_addr     (init_addr),
        .init_data     (init_data),
        .init_wren     (init_wren),
        .ksa_addr      (ksa_addr),
        .ksa_data      (ksa_data),
        .ksa_wren      (ksa_wren),
        .prga_addr     (prga_addr),
        .prga_data     (prga_data),
        .prga_wren     (prga_wren),
        .s_memory_addr (s_memory_addr),
        .s_memory_data (s_memory_data),
        .s_wren        (s_wren)
    );

    assign phase = phase_q;
    assign state = {12'd0, state_q};

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Scoreboard bench for rc4_phase_sequencer: directed runs push expected snapshots and
// start/done events; a negedge monitor pops and compares them.
module tb_rc4_phase_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned KEY_W  = 24;
    localparam int unsigned WD     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [KEY_W-1:0]  key_in = '0;
    logic [KEY_W-1:0]  key_out;
    logic              init_start, ksa_start, prga_start;
    logic              init_done, ksa_done, prga_done;
    logic              init_done_a = 1'b0, ksa_done_a = 1'b0, prga_done_a = 1'b0;
    logic              init_done_m = 1'b0, ksa_done_m = 1'b0, prga_done_m = 1'b0;
    logic              auto_init = 1'b1, auto_ksa = 1'b1, auto_prga = 1'b1;
    logic [ADDR_W-1:0] init_addr = '0, ksa_addr = '0, prga_addr = '0;
    logic [DATA_W-1:0] init_data = '0, ksa_data = '0, prga_data = '0;
    logic              init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
    logic [ADDR_W-1:0] s_memory_addr;
    logic [DATA_W-1:0] s_memory_data;
    logic              s_wren, busy, done, error;
    logic [1:0]        phase;
    logic [15:0]       state;

    assign init_done = init_done_a | init_done_m;
    assign ksa_done  = ksa_done_a  | ksa_done_m;
    assign prga_done = prga_done_a | prga_done_m;

    rc4_phase_sequencer #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .KEY_W           (KEY_W),
        .WATCHDOG_CYCLES (WD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .key_in        (key_in),
        .key_out       (key_out),
        .init_start    (init_start),
        .ksa_start     (ksa_start),
        .prga_start    (prga_start),
        .init_done     (init_done),
        .ksa_done      (ksa_done),
        .prga_done     (prga_done),
        .init_addr     (init_addr),
        .init_data     (init_data),
        .init_wren     (init_wren),
        .ksa_addr      (ksa_addr),
        .ksa_data      (ksa_data),
        .ksa_wren      (ksa_wren),
        .prga_addr     (prga_addr),
        .prga_data     (prga_data),
        .prga_wren     (prga_wren),
        .s_memory_addr (s_memory_addr),
        .s_memory_data (s_memory_data),
        .s_wren        (s_wren),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .phase         (phase),
        .state         (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic        busy;
        logic        done;
        logic        error;
        logic [1:0]  phase;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic        wren;
        logic [23:0] key;
    } snap_t;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    snap_t snap_q[$];
    ev_t   ev_q[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    base = 0;
    logic  snap_req = 1'b0;
    logic  done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_ev(input int k, input logic fired);
        ev_t e;
        if (fired) begin
            if (ev_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL event: unexpected kind %0d at cycle %0d, expected none", k, cyc);
            end else begin
                e = ev_q.pop_front();
                chk("event.kind", k, e.kind);
                chk("event.cycle", cyc, e.cyc);
            end
        end
    endtask

    // Monitor: compares pending snapshots and every start pulse / done rise.
    always @(negedge clk) begin
        snap_t s;
        if (snap_req) begin
            if (snap_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL snapshot: request with empty queue at cycle %0d", cyc);
            end else begin
                s = snap_q.pop_front();
                chk({s.name, ".state"}, 32'(state), 32'(s.st));
                chk({s.name, ".busy"},  32'(busy),  32'(s.busy));
                chk({s.name, ".done"},  32'(done),  32'(s.done));
                chk({s.name, ".error"}, 32'(error), 32'(s.error));
                chk({s.name, ".phase"}, 32'(phase), 32'(s.phase));
                chk({s.name, ".addr"},  32'(s_memory_addr), 32'(s.addr));
                chk({s.name, ".data"},  32'(s_memory_data), 32'(s.data));
                chk({s.name, ".wren"},  32'(s_wren), 32'(s.wren));
                chk({s.name, ".key"},   32'(key_out), 32'(s.key));
            end
        end
        check_ev(0, init_start);
        check_ev(1, ksa_start);
        check_ev(2, prga_start);
        check_ev(3, done && !done_prev);
        done_prev = done;
    end

    // Phase models: when enabled, answer a start pulse with done in the first WAIT cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (init_start && auto_init) begin
                @(posedge clk); #1 init_done_a = 1'b1;
                @(posedge clk); #1 init_done_a = 1'b0;
            end else if (ksa_start && auto_ksa) begin
                @(posedge clk); #1 ksa_done_a = 1'b1;
                @(posedge clk); #1 ksa_done_a = 1'b0;
            end else if (prga_start && auto_prga) begin
                @(posedge clk); #1 prga_done_a = 1'b1;
                @(posedge clk); #1 prga_done_a = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string nm, input logic [3:0] st, input logic b, input logic d,
                        input logic e, input logic [1:0] ph, input logic [7:0] a,
                        input logic [7:0] dt, input logic w, input logic [23:0] k);
        snap_t s;
        s.name = nm; s.st = st; s.busy = b; s.done = d; s.error = e; s.phase = ph;
        s.addr = a; s.data = dt; s.wren = w; s.key = k;
        snap_q.push_back(s);
        snap_req = 1'b1;
        @(negedge clk);
        #1 snap_req = 1'b0;
    endtask

    task automatic expect_ev(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc = c;
        ev_q.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        rst = 1'b1;
        step();
        snap("reset", 4'd0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 24'h0);

        init_addr = 8'h11; init_data = 8'h22; init_wren = 1'b1;
        snap("idle_blocked", 4'd0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 24'h0);

        // Start, park in INIT_WAIT, check grant and stray prga_done, then reset mid-phase.
        step();
        auto_init = 1'b0;
        key_in = 24'h123456;
        start = 1'b1;
        base = cyc;
        expect_ev(0, base + 1);
        step();
        start = 1'b0;
        step();
        snap("init_grant", 4'd2, 1, 0, 0, 2'd1, 8'h11, 8'h22, 1, 24'h123456);
        prga_done_m = 1'b1;
        step();
        prga_done_m = 1'b0;
        snap("stray_done", 4'd2, 1, 0, 0, 2'd1, 8'h11, 8'h22, 1, 24'h123456);
        step();
        rst = 1'b0;
        snap("reset_mid", 4'd0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 24'h0);
        step();
        rst = 1'b1;
        auto_init = 1'b1;
        init_wren = 1'b0; init_addr = '0; init_data = '0;
        snap("after_reset", 4'd0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 24'h0);

        // Minimum-latency run.
        step();
        key_in = 24'hABCDEF;
        start = 1'b1;
        base = cyc;
        expect_ev(0, base + 1); expect_ev(1, base + 3);
        expect_ev(2, base + 5); expect_ev(3, base + 7);
        step();
        start = 1'b0;
        repeat (6) step();
        snap("run_done", 4'd7, 0, 1, 0, 2'd0, 8'h00, 8'h00, 0, 24'hABCDEF);

        // Hold the key schedule to test the mux, start-while-busy and the timeout behaviour.
        step();
        auto_ksa = 1'b0;
        key_in = 24'h5A5A5A;
        start = 1'b1;
        base = cyc;
        expect_ev(0, base + 1); expect_ev(1, base + 3);
        step();
        start = 1'b0;
        repeat (3) step();
        ksa_addr = 8'h3C; ksa_data = 8'hA5; ksa_wren = 1'b1;
        init_addr = 8'h11; init_data = 8'h22; init_wren = 1'b1;
        prga_addr = 8'h77; prga_data = 8'h88; prga_wren = 1'b1;
        snap("ksa_grant", 4'd4, 1, 0, 0, 2'd2, 8'h3C, 8'hA5, 1, 24'h5A5A5A);
        key_in = 24'hFFFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        snap("busy_start", 4'd4, 1, 0, 0, 2'd2, 8'h3C, 8'hA5, 1, 24'h5A5A5A);
`ifdef RC4_SEQ_WATCHDOG_EN
        repeat (14) step();
        snap("wd_pre", 4'd4, 1, 0, 0, 2'd2, 8'h3C, 8'hA5, 1, 24'h5A5A5A);
        step();
        snap("wd_error", 4'd8, 0, 0, 1, 2'd0, 8'h00, 8'h00, 0, 24'h5A5A5A);

        // Restart out of ERROR and let ksa_done coincide with expiry.
        step();
        key_in = 24'h0F0F0F;
        start = 1'b1;
        base = cyc;
        expect_ev(0, base + 1); expect_ev(1, base + 3);
        expect_ev(2, base + 20); expect_ev(3, base + 22);
        step();
        start = 1'b0;
        repeat (18) step();
        ksa_done_m = 1'b1;
        step();
        ksa_done_m = 1'b0;
        snap("done_wins", 4'd5, 1, 0, 0, 2'd3, 8'h77, 8'h88, 1, 24'h0F0F0F);
        step();
        step();
        snap("done2", 4'd7, 0, 1, 0, 2'd0, 8'h00, 8'h00, 0, 24'h0F0F0F);
`else
        repeat (10000) step();
        snap("no_wd", 4'd4, 1, 0, 0, 2'd2, 8'h3C, 8'hA5, 1, 24'h5A5A5A);
        ksa_done_m = 1'b1;
        base = cyc;
        expect_ev(2, base + 1); expect_ev(3, base + 3);
        step();
        ksa_done_m = 1'b0;
        step();
        step();
        snap("done2", 4'd7, 0, 1, 0, 2'd0, 8'h00, 8'h00, 0, 24'h5A5A5A);
`endif

        // New run started from DONE latches the new key.
        auto_ksa = 1'b1;
        init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
        init_addr = '0; init_data = '0; ksa_addr = '0; ksa_data = '0;
        prga_addr = '0; prga_data = '0;
        step();
        key_in = 24'h000249;
        start = 1'b1;
        base = cyc;
        expect_ev(0, base + 1); expect_ev(1, base + 3);
        expect_ev(2, base + 5); expect_ev(3, base + 7);
        step();
        start = 1'b0;
        key_in = 24'h000000;
        snap("restart_go", 4'd1, 1, 0, 0, 2'd1, 8'h00, 8'h00, 0, 24'h000249);
        repeat (6) step();
        snap("restart_done", 4'd7, 0, 1, 0, 2'd0, 8'h00, 8'h00, 0, 24'h000249);

        repeat (3) step();
        chk("events_left", 32'(ev_q.size()), 32'd0);
        chk("snaps_left", 32'(snap_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
